// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM states, access-size
// encoding and the default array depth.
package mem_pkg;

  localparam int DEPTH_DEFAULT = 1024;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    HALF = 2'b01,
    BYTE = 2'b10
  } size_e;

  // Byte select wins over half select when both are set.
  function automatic size_e decode_size(input logic is_half, input logic is_byte);
    if (is_byte) begin
      return BYTE;
    end else if (is_half) begin
      return HALF;
    end
    return WORD;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the EX/MEM stage and the
// data-memory responder.
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_half;
  logic        req_byte;
  logic        req_unsigned;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
           req_half, req_byte, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
           req_half, req_byte, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

endinterface

// File: rtl/data_lane_align.sv
// Combinational lane steering: merges store data into the addressed lanes of
// the old word, extracts and extends load data, and flags misaligned accesses.
module data_lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] st_word,
  output logic [31:0] ld_val,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        ext_bit;

  // Misalignment: words need addr[1:0]=0, halves need addr[0]=0.
  always_comb begin
    misalign = 1'b0;
    case (size)
      WORD:    misalign = (addr_lo != 2'b00);
      HALF:    misalign = addr_lo[0];
      default: misalign = 1'b0;
    endcase
  end

  // Pick the addressed lane out of the old word (little-endian lanes).
  always_comb begin
    sel_byte = old_word[7:0];
    case (addr_lo)
      2'd0:    sel_byte = old_word[7:0];
      2'd1:    sel_byte = old_word[15:8];
      2'd2:    sel_byte = old_word[23:16];
      default: sel_byte = old_word[31:24];
    endcase
    sel_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];
  end

  // Shift the selected lane to bit 0 and sign- or zero-extend it.
  always_comb begin
    ld_val  = old_word;
    ext_bit = 1'b0;
    case (size)
      BYTE: begin
        ext_bit = ~is_unsigned & sel_byte[7];
        ld_val  = {{24{ext_bit}}, sel_byte};
      end
      HALF: begin
        ext_bit = ~is_unsigned & sel_half[15];
        ld_val  = {{16{ext_bit}}, sel_half};
      end
      default: ld_val = old_word;
    endcase
  end

  // Replace only the addressed lanes; untouched bytes keep their old value.
  always_comb begin
    st_word = old_word;
    case (size)
      BYTE: begin
        case (addr_lo)
          2'd0:    st_word[7:0]   = wdata[7:0];
          2'd1:    st_word[15:8]  = wdata[7:0];
          2'd2:    st_word[23:16] = wdata[7:0];
          default: st_word[31:24] = wdata[7:0];
        endcase
      end
      HALF: begin
        if (addr_lo[1]) begin
          st_word[31:16] = wdata[15:0];
        end else begin
          st_word[15:0] = wdata[15:0];
        end
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: owns the data array, clears it after reset, then
// serves one load/store per cycle with a registered one-cycle response.
//
//   state | meaning
//   CLEAR | writing 0 to word[clr_cnt], requests refused
//   RUN   | accepting one request per cycle until reset
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  data_mem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  state_e          state;
  state_e          state_nx;
  logic [AW-1:0]   clr_cnt;
  logic [AW-1:0]   clr_cnt_nx;

  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic [AW-1:0]   word_idx;
  size_e           size;
  logic [31:0]     old_word;
  logic [31:0]     st_word;
  logic [31:0]     ld_val;
  logic            misalign;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;

  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;

  logic            unused_addr;

  assign word_idx    = bus.req_addr[AW+1:2];
  assign unused_addr = ^bus.req_addr[31:AW+2];
  assign size        = decode_size(bus.req_half, bus.req_byte);
  assign old_word    = mem[word_idx];

  assign bus.req_ready = (state == RUN);
  assign bus.init_done = (state == RUN);
  assign accept        = bus.req_valid && (state == RUN);

  data_lane_align u_align (
    .size        (size),
    .addr_lo     (bus.req_addr[1:0]),
    .is_unsigned (bus.req_unsigned),
    .wdata       (bus.req_wdata),
    .old_word    (old_word),
    .st_word     (st_word),
    .ld_val      (ld_val),
    .misalign    (misalign)
  );

  // State and clear-counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  // Next state and the single array write port, shared by clear and stores.
  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    mem_we     = 1'b0;
    mem_waddr  = word_idx;
    mem_wdata  = st_word;
    case (state)
      CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_cnt;
        mem_wdata  = '0;
        clr_cnt_nx = clr_cnt + AW'(1);
        if (clr_cnt == AW'(DEPTH - 1)) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        mem_we = accept && bus.req_write && !misalign;
      end
      default: state_nx = CLEAR;
    endcase
  end

  // Array write; no reset so the array maps onto a plain RAM.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered response: one pulse per accept, data zeroed for stores/errors.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= misalign;
      rsp_rdata_q <= (bus.req_write || misalign) ? '0 : ld_val;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of requests with hand-computed
// responses, plus reset/clear and mid-operation reset sequences.
module tb_data_mem_responder;
  import mem_pkg::*;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;      // 0 word, 1 half, 2 byte, 3 byte+half
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 Clk = ~Clk;

  data_mem_responder_if bus();

  data_mem_responder dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  function automatic vec_t mk(logic wr, logic [1:0] sz, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_half     = 1'b0;
    bus.req_byte     = 1'b0;
    bus.req_unsigned = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid    = 1'b1;
    bus.req_write    = v.wr;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_half     = v.sz[0];
    bus.req_byte     = v.sz[1];
    bus.req_unsigned = v.uns;
  endtask

  // Applies vecs[lo..hi] back-to-back, one per cycle, checking each response
  // at the negedge after its accept edge; then checks the idle cycle.
  task automatic run_range(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i]);
      @(negedge Clk);
      check($sformatf("%s%0d_valid", tag, i - lo), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("%s%0d_rdata", tag, i - lo), bus.rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("%s%0d_err", tag, i - lo), 32'(bus.rsp_err), 32'(vecs[i].exp_err));
    end
    drive_idle();
    @(negedge Clk);
    check($sformatf("%s_idle_valid", tag), 32'(bus.rsp_valid), 32'd0);
    check($sformatf("%s_idle_rdata", tag), bus.rsp_rdata, 32'd0);
  endtask

  // Counts negedges from reset release until init_done, bounded.
  task automatic wait_init(output int n, output int vhits);
    n = 0;
    vhits = 0;
    while (n < 2000) begin
      @(negedge Clk);
      n++;
      if (bus.rsp_valid) vhits++;
      if (bus.init_done) break;
    end
  endtask

  initial begin
    int n, vh;
    int a0, a1, b0, b1, c0, c1, d0, d1;

    drive_idle();

    a0 = vecs.size();
    vecs.push_back(mk(1, 0, 0, 32'h14, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h14, 32'h0, 32'hDEADBEEF, 0));
    a1 = vecs.size() - 1;

    b0 = vecs.size();
    vecs.push_back(mk(0, 0, 0, 32'h14, 32'h0, 32'h00000000, 0));
    vecs.push_back(mk(1, 0, 0, 32'h40, 32'h12345678, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h40, 32'h0, 32'h12345678, 0));
    vecs.push_back(mk(1, 2, 0, 32'h41, 32'hFFFFFFAB, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h40, 32'h0, 32'h1234AB78, 0));
    vecs.push_back(mk(0, 2, 0, 32'h41, 32'h0, 32'hFFFFFFAB, 0));
    vecs.push_back(mk(0, 2, 1, 32'h41, 32'h0, 32'h000000AB, 0));
    vecs.push_back(mk(0, 1, 0, 32'h42, 32'h0, 32'h00001234, 0));
    vecs.push_back(mk(0, 1, 0, 32'h40, 32'h0, 32'hFFFFAB78, 0));
    vecs.push_back(mk(0, 1, 1, 32'h40, 32'h0, 32'h0000AB78, 0));
    vecs.push_back(mk(1, 0, 0, 32'h42, 32'hCAFEF00D, 32'h0, 1));
    vecs.push_back(mk(0, 1, 0, 32'h43, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h40, 32'h0, 32'h1234AB78, 0));
    vecs.push_back(mk(1, 1, 0, 32'h46, 32'h55559876, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h44, 32'h0, 32'h98760000, 0));
    vecs.push_back(mk(0, 2, 0, 32'h47, 32'h0, 32'hFFFFFF98, 0));
    vecs.push_back(mk(1, 3, 0, 32'h45, 32'h00000011, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h44, 32'h0, 32'h98761100, 0));
    vecs.push_back(mk(0, 2, 1, 32'h45, 32'h0, 32'h00000011, 0));
    vecs.push_back(mk(0, 0, 0, 32'h41, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 1, 0, 32'h41, 32'h0000FFFF, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h40, 32'h0, 32'h1234AB78, 0));
    vecs.push_back(mk(0, 0, 1, 32'h44, 32'h0, 32'h98761100, 0));
    b1 = vecs.size() - 1;

    c0 = vecs.size();
    vecs.push_back(mk(1, 0, 0, 32'h80, 32'h11111111, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h1040, 32'h0BADF00D, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h40, 32'h0, 32'h0BADF00D, 0));
    vecs.push_back(mk(0, 0, 0, 32'h80, 32'h0, 32'h11111111, 0));
    vecs.push_back(mk(1, 2, 0, 32'h83, 32'h00000022, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h80, 32'h0, 32'h22111111, 0));
    vecs.push_back(mk(0, 0, 0, 32'h2040, 32'h0, 32'h0BADF00D, 0));
    vecs.push_back(mk(0, 1, 1, 32'h1082, 32'h0, 32'h00002211, 0));
    c1 = vecs.size() - 1;

    d0 = vecs.size();
    vecs.push_back(mk(0, 0, 0, 32'h40, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h80, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h44, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h14, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'hFFC, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0));
    d1 = vecs.size() - 1;

    // Reset values while Reset is held.
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);

    @(negedge Clk);
    Reset = 1'b0;
    wait_init(n, vh);
    check("init1_cycles", 32'(n), 32'd1024);

    // Pre-load word 5, then reset and confirm the clear wiped it.
    run_range("pre", a0, a1);
    Reset = 1'b1;
    #1;
    check("rst2_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst2_init_done", 32'(bus.init_done), 32'd0);
    @(negedge Clk);
    // Requests offered during CLEAR must be ignored.
    drive(mk(1, 0, 0, 32'h14, 32'hFFFFFFFF, 32'h0, 0));
    Reset = 1'b0;
    wait_init(n, vh);
    check("init2_cycles", 32'(n), 32'd1024);
    check("init2_no_rsp", 32'(vh), 32'd0);
    check("init2_ready", 32'(bus.req_ready), 32'd1);

    run_range("main", b0, b1);
    run_range("b2b", c0, c1);

    // Reset the cycle after a load accept: the response must be dropped.
    drive(mk(0, 0, 0, 32'h40, 32'h0, 32'h0, 0));
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("mid_req_ready", 32'(bus.req_ready), 32'd0);
    check("mid_init_done", 32'(bus.init_done), 32'd0);
    drive_idle();
    @(negedge Clk);
    Reset = 1'b0;
    wait_init(n, vh);
    check("init3_cycles", 32'(n), 32'd1024);
    check("init3_no_rsp", 32'(vh), 32'd0);

    run_range("probe", d0, d1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
